// File: rtl/histogram_pkg.sv
// ----------------------------------------------------------------------------
// histogram_pkg
// Shared definitions for the histogram block and its post-processing stages.
//   HIST_BINS    : number of histogram bins (power of two)
//   HIST_ADDR_W  : bin address width, log2(HIST_BINS)
//   HIST_DATA_W  : bin / CDF word width
//   cdf_state_t  : state encoding of the histogram_cdf sequencer
// ----------------------------------------------------------------------------
package histogram_pkg;

    localparam int HIST_BINS   = 256;
    localparam int HIST_ADDR_W = 8;
    localparam int HIST_DATA_W = 32;

    typedef enum logic [1:0] {
        CDF_IDLE,
        CDF_RUN,
        CDF_DRAIN,
        CDF_DONE
    } cdf_state_t;

endpackage

// File: rtl/histogram_cdf_if.sv
// ----------------------------------------------------------------------------
// histogram_cdf_if
// Bundles the control, bin-memory and CDF-memory signals of histogram_cdf.
//   master modport : the histogram_cdf block
//   slave  modport : the surrounding memories / controller
// Signals:
//   start       : single-cycle pass request
//   hist_raddr  : bin memory read address
//   hist_rdata  : bin memory read data (1-cycle latency)
//   cdf_waddr   : CDF memory write address
//   cdf_wdata   : CDF memory write data
//   cdf_wen     : CDF memory write strobe
//   busy / done : pass in progress / end-of-pass pulse
//   total       : final sum of all bins
//   overflow    : sticky prefix-sum saturation flag
// Optional (HISTOGRAM_CDF_CLEAR_EN): hist_waddr, hist_wdata, hist_wen, a
// write port used to zero each bin as it is consumed.
// ----------------------------------------------------------------------------
interface histogram_cdf_if
    import histogram_pkg::*;
#(
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int DATA_W = HIST_DATA_W
) ();

    logic              start;
    logic [ADDR_W-1:0] hist_raddr;
    logic [DATA_W-1:0] hist_rdata;
    logic [ADDR_W-1:0] cdf_waddr;
    logic [DATA_W-1:0] cdf_wdata;
    logic              cdf_wen;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] total;
    logic              overflow;
`ifdef HISTOGRAM_CDF_CLEAR_EN
    logic [ADDR_W-1:0] hist_waddr;
    logic [DATA_W-1:0] hist_wdata;
    logic              hist_wen;
`endif

`ifdef HISTOGRAM_CDF_CLEAR_EN
    modport master (
        input  start, hist_rdata,
        output hist_raddr, cdf_waddr, cdf_wdata, cdf_wen,
        output busy, done, total, overflow,
        output hist_waddr, hist_wdata, hist_wen
    );

    modport slave (
        output start, hist_rdata,
        input  hist_raddr, cdf_waddr, cdf_wdata, cdf_wen,
        input  busy, done, total, overflow,
        input  hist_waddr, hist_wdata, hist_wen
    );
`else
    // Bin memory is read-only to the CDF stage in this build.
    modport master (
        input  start, hist_rdata,
        output hist_raddr, cdf_waddr, cdf_wdata, cdf_wen,
        output busy, done, total, overflow
    );

    modport slave (
        output start, hist_rdata,
        input  hist_raddr, cdf_waddr, cdf_wdata, cdf_wen,
        input  busy, done, total, overflow
    );
`endif

endinterface

// File: rtl/histogram_cdf_sat_add.sv
// ----------------------------------------------------------------------------
// sat_add
// Combinational unsigned saturating adder.
//   a, b : WIDTH-bit operands
//   sum  : a + b, clamped to all-ones when the true sum does not fit
//   sat  : high when clamping occurred (carry out of the WIDTH-bit add)
// ----------------------------------------------------------------------------
module sat_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             sat
);

    logic [WIDTH:0] wide_sum;

    // One extra bit catches the carry; any carry means the result clamps.
    always_comb begin
        wide_sum = {1'b0, a} + {1'b0, b};
        sat      = wide_sum[WIDTH];
        sum      = wide_sum[WIDTH] ? {WIDTH{1'b1}} : wide_sum[WIDTH-1:0];
    end

endmodule

// File: rtl/histogram_cdf.sv
// ----------------------------------------------------------------------------
// histogram_cdf
// Walks the histogram bin memory in address order and writes the running
// (saturating) prefix sum into a CDF memory, one bin per cycle. Reports the
// grand total and a sticky saturation flag at the end of each pass.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : histogram_cdf_if.master (start, bin read port, CDF write port,
//          busy, done, total, overflow)
// Build option: define HISTOGRAM_CDF_CLEAR_EN to add a bin write port that
// zeroes each bin in the same cycle its CDF value is written.
// ----------------------------------------------------------------------------
module histogram_cdf
    import histogram_pkg::*;
#(
    parameter int BINS   = HIST_BINS,
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int DATA_W = HIST_DATA_W
) (
    input logic            clk,
    input logic            rst,
    histogram_cdf_if.master bus
);

    cdf_state_t        state_q,    state_d;
    logic [ADDR_W-1:0] rd_idx_q,   rd_idx_d;
    logic [ADDR_W-1:0] wr_idx_q,   wr_idx_d;
    logic              rd_val_q,   rd_val_d;
    logic [DATA_W-1:0] acc_q,      acc_d;
    logic [DATA_W-1:0] total_q,    total_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] sum;
    logic              sum_sat;

    sat_add #(.WIDTH(DATA_W)) u_sat_add (
        .a   (acc_q),
        .b   (bus.hist_rdata),
        .sum (sum),
        .sat (sum_sat)
    );

    // Next-state logic. The return pipeline (rd_val/wr_idx) trails the read
    // issue by one cycle to match the bin memory latency. Once the sum has
    // clamped, acc sits at all-ones and every further add clamps again, so
    // the saturated value persists without extra state.
    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        acc_d      = acc_q;
        total_d    = total_q;
        overflow_d = overflow_q;
        rd_val_d   = (state_q == CDF_RUN);
        wr_idx_d   = rd_idx_q;

        if (rd_val_q) begin
            acc_d = sum;
            if (sum_sat) begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            CDF_IDLE: begin
                if (bus.start) begin
                    state_d    = CDF_RUN;
                    rd_idx_d   = '0;
                    acc_d      = '0;
                    overflow_d = 1'b0;
                end
            end
            CDF_RUN: begin
                // The index holds on the last bin so hist_raddr keeps it.
                if (rd_idx_q == ADDR_W'(BINS - 1)) begin
                    state_d = CDF_DRAIN;
                end else begin
                    rd_idx_d = rd_idx_q + ADDR_W'(1);
                end
            end
            CDF_DRAIN: begin
                state_d = CDF_DONE;
            end
            CDF_DONE: begin
                total_d = acc_q;
                state_d = CDF_IDLE;
            end
            default: begin
                state_d = CDF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CDF_IDLE;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            rd_val_q   <= 1'b0;
            acc_q      <= '0;
            total_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            rd_val_q   <= rd_val_d;
            acc_q      <= acc_d;
            total_q    <= total_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.hist_raddr = rd_idx_q;
    assign bus.cdf_wen    = rd_val_q;
    assign bus.cdf_waddr  = wr_idx_q;
    // Data is forced to zero outside write cycles so it never shows stale sums.
    assign bus.cdf_wdata  = rd_val_q ? sum : '0;
    assign bus.busy       = (state_q == CDF_RUN) || (state_q == CDF_DRAIN);
    assign bus.done       = (state_q == CDF_DONE);
    assign bus.total      = total_q;
    assign bus.overflow   = overflow_q;

`ifdef HISTOGRAM_CDF_CLEAR_EN
    // Each consumed bin is zeroed alongside its CDF write.
    assign bus.hist_waddr = wr_idx_q;
    assign bus.hist_wdata = '0;
    assign bus.hist_wen   = rd_val_q;
`else
    // No bin write port: the bin memory is only read.
`endif

endmodule

// File: doc/histogram_cdf.md
# histogram_cdf

Post-processing stage placed directly downstream of `histogram`. Once the histogram reports `valid`, this block walks the 256-entry bin memory (`histogram`'s `arg_1`) in address order and writes the running prefix sum (the cumulative distribution) into a separate CDF memory. It also reports the grand total and a saturation flag. The CDF memory feeds the histogram-equalisation LUT stage.

## Interface
Parameters:
- `BINS`, 256, number of bins; must be a power of two.
- `ADDR_W`, 8, bin address width; equals log2(`BINS`).
- `DATA_W`, 32, bin and CDF word width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle request; normally tied to `histogram.valid` through an edge detector.
- `hist_raddr`  out  `ADDR_W`  bin memory read address.
- `hist_rdata`  in  `DATA_W`  bin memory read data; 1-cycle read latency.
- `cdf_waddr`  out  `ADDR_W`  CDF memory write address.
- `cdf_wdata`  out  `DATA_W`  CDF value.
- `cdf_wen`  out  1  CDF write strobe.
- `busy`  out  1  high while a pass is in progress.
- `done`  out  1  1-cycle pulse at the end of a pass.
- `total`  out  `DATA_W`  final sum of all bins; held until the next `start`.
- `overflow`  out  1  sticky flag; set if any prefix sum saturated.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 → RUN.
  - On that transition: clear `rd_idx`, `acc`, and `overflow`.
- RUN:
  - `hist_raddr` = `rd_idx`.
  - `rd_idx` increments every cycle.
  - When `rd_idx` = `BINS`-1 is issued → DRAIN.
- Return pipeline:
  - A valid bit and an index register (`wr_idx`) are delayed one cycle behind the read issue.
  - When the valid bit is set: `cdf_wen`=1, `cdf_waddr`=`wr_idx`, `cdf_wdata`=sat(`acc` + `hist_rdata`).
  - `acc` takes that same value at the clock edge.
- DRAIN: performs the final write for index `BINS`-1, then → DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - `total` is loaded with the final `acc`.
  - → IDLE.
- Arithmetic:
  - The adder is `DATA_W`+1 bits wide.
  - On carry-out the result clamps to 2^`DATA_W`-1 and `overflow` is set.
  - The sum then stays clamped for all remaining indices.
- `start` while not IDLE is ignored; it is neither queued nor restarts the pass.
- `hist_raddr` holds its last value when not in RUN. `cdf_wen`=0 outside write cycles.
- Reset values:
  - state IDLE.
  - `hist_raddr`=0, `cdf_waddr`=0, `cdf_wdata`=0, `cdf_wen`=0.
  - `busy`=0, `done`=0, `total`=0, `overflow`=0.
  - Internal `acc`=0, `rd_idx`=0, valid bit=0.
- Reset during a pass:
  - The pass is abandoned and no further writes are issued.
  - `done` is not pulsed.
  - CDF memory contents are undefined until the next complete pass.

## Timing
- `start` sampled high at cycle t0:
  - RUN is entered at t0+1, with `hist_raddr`=0 in that cycle.
  - Read k is issued at t0+1+k.
  - The write for k occurs at t0+2+k.
- Last write (k=`BINS`-1) at t0+`BINS`+1; `done` at t0+`BINS`+2 (t0+258 for 256 bins).
- `busy` is high from t0+1 through t0+`BINS`+1 inclusive, and low in the `done` cycle.
- Throughput: one bin per cycle, no stalls. The bin memory must not be written by `histogram` while `busy`=1.

## Configuration
- `HISTOGRAM_CDF_CLEAR_EN` defined:
  - Adds ports `hist_waddr` (out, `ADDR_W`), `hist_wdata` (out, `DATA_W`), `hist_wen` (out, 1).
  - In each CDF write cycle the block also writes 0 to bin `wr_idx`, leaving the histogram zeroed for the next frame.
  - `hist_wen` resets to 0.
- Undefined: those ports are absent and the bin memory is read-only to this block.

## Structure
- Shared package `histogram_pkg`:
  - constants `HIST_BINS`=256, `HIST_ADDR_W`=8, `HIST_DATA_W`=32 (shared with `histogram`).
  - state enum type `cdf_state_t`.
- One sub-module, `sat_add`: parameter `WIDTH`, inputs `a` and `b`, outputs `sum` and `sat`. Purely combinational, used for the accumulator.
- FSM, counters and pipeline register live in `histogram_cdf`.

## Test plan
- All bins 0, `start` at t0 → 256 writes with `cdf_wdata`=0, `done` at t0+258, `total`=0, `overflow`=0.
- All bins 1 → `cdf[k]`=k+1 at cycle t0+2+k, `total`=256, `busy` low at t0+258.
- Only bin 255 = 100 → `cdf[0..254]`=0, `cdf[255]`=100, `total`=100.
- `bin[0]`=0xFFFF_FFF0, `bin[1]`=0x20, others 1 → `cdf[1..255]`=0xFFFF_FFFF, `overflow`=1; a following pass with all zeros clears `overflow`.
- `start` pulsed again at t0+50 → ignored; exactly 256 writes and one `done`. `rst` asserted at t0+100 → `cdf_wen`=0 from the next cycle, no `done`; a new `start` then completes normally.
- `HISTOGRAM_CDF_CLEAR_EN` build, all bins 3 → `cdf[k]`=3(k+1), and every bin reads 0 after `done`.
